lsu_ctrl: RTL and testbench

- Load/store control stage directly upstream of the MIPS word-indexed data memory.
- Takes byte-addressed load/store requests from the execute/memory pipeline stage and converts them to word-index accesses.
- Supported sizes: byte, halfword and word. Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
- Drives the memory's A/wd/we inputs and consumes its combinational rd.

---
 rtl/lsu_pkg.sv | 8 +
 rtl/lsu_lane_fmt.sv | 31 +++
 rtl/lsu_ctrl.sv | 114 +++++++++++
 tb/tb_lsu_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size/state encodings and default memory depth for the load/store unit
package lsu_pkg;
  localparam int DEPTH_DEF = 32;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RSP} state_t;
endpackage

// File: rtl/lsu_lane_fmt.sv
// lsu_lane_fmt: combinational lane logic (load extract/extend, store merge, alignment check)
// Ports: size_i/lane_i select the access, unsigned_i picks zero-extension, word_i is the
// memory word, wdata_i the store data; ld_o extended load, st_o merged store word,
// misalign_o flags misaligned or illegal-size accesses.
module lsu_lane_fmt
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_o,
  output logic [31:0] st_o,
  output logic        misalign_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word_i[{lane_i, 3'b000} +: 8];
  assign h = lane_i[1] ? word_i[31:16] : word_i[15:0];
  assign ld_o = size_i == SZ_BYTE ? {{24{b[7] & ~unsigned_i}}, b} :
                size_i == SZ_HALF ? {{16{h[15] & ~unsigned_i}}, h} : word_i;
  assign misalign_o = (size_i == SZ_HALF && lane_i[0]) ||
                      (size_i == SZ_WORD && lane_i != 2'b00) ||
                      (size_i == 2'b11);
  always_comb begin
    st_o = size_i == SZ_WORD ? wdata_i : word_i;
    if (size_i == SZ_BYTE) st_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
    else if (size_i == SZ_HALF) st_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: byte-addressed load/store control in front of a word-indexed data memory
// Ports: req_* request handshake (valid/ready, we, size, unsigned, addr, wdata);
// resp_valid/resp_rdata/resp_err one-cycle response; mem_a/mem_wd/mem_we drive the
// memory, mem_rd is its combinational read data.
// Optional: define LSU_RANGE_CHECK_EN to flag addresses beyond DEPTH words as errors.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);
  state_t state_q, state_d;
  logic we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0] size_q, size_d;
  logic [IDX_W+1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, old_q, old_d, rdata_q, rdata_d;
  logic idle, misalign, range_err;
  logic [31:0] ld, st;
  assign idle = state_q == ST_IDLE;
`ifdef LSU_RANGE_CHECK_EN
  assign range_err = |req_addr[31:IDX_W+2];
`else
  logic unused_hi;
  assign unused_hi = ^req_addr[31:IDX_W+2];
  assign range_err = 1'b0;
`endif
  // Alignment is judged on the live request in IDLE; afterwards the latched request drives the lanes.
  lsu_lane_fmt u_fmt (
    .size_i    (idle ? req_size : size_q),
    .unsigned_i(uns_q),
    .lane_i    (idle ? req_addr[1:0] : addr_q[1:0]),
    .word_i    (state_q == ST_WR ? old_q : mem_rd),
    .wdata_i   (wdata_q),
    .ld_o      (ld),
    .st_o      (st),
    .misalign_o(misalign)
  );
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    rdata_d = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        we_d    = req_we;
        uns_d   = req_unsigned;
        size_d  = req_size;
        addr_d  = req_addr[IDX_W+1:0];
        wdata_d = req_wdata;
        err_d   = misalign | range_err;
        state_d = err_d ? ST_RSP : (req_we && req_size == SZ_WORD) ? ST_WR : ST_RD;
      end
      ST_RD: begin
        old_d   = mem_rd;
        rdata_d = we_q ? '0 : ld;
        state_d = we_q ? ST_WR : ST_RSP;
      end
      ST_WR:   state_d = ST_RSP;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
    end
  end
  assign req_ready  = idle;
  assign resp_valid = state_q == ST_RSP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_a  = (state_q == ST_RD || state_q == ST_WR) ? {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]} : '0;
  assign mem_we = state_q == ST_WR && !rst;
  assign mem_wd = state_q == ST_WR ? st : '0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl with a behavioural data memory
module tb_lsu_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;
  logic [31:0] mem [32];
  int checks = 0, errors = 0, we_cnt = 0, we0, lat;
  logic [31:0] last_a, last_wd, r_data;
  logic r_err, r_vld, r_after, seen_vld;

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  assign mem_rd = mem[mem_a[4:0]];
  always @(posedge clk) if (mem_we) begin
    mem[mem_a[4:0]] <= mem_wd;
    we_cnt <= we_cnt + 1;
    last_a <= mem_a;
    last_wd <= mem_wd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    we0 = we_cnt;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      #1 lat++;
    end
    r_vld = resp_valid; r_data = resp_rdata; r_err = resp_err;
    @(posedge clk);
    #1 r_after = resp_valid;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    rst = 1'b0;

    req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
    chk("sw_valid", {31'b0, r_vld}, 32'd1);
    chk("sw_lat", lat, 32'd2);
    chk("sw_we_count", we_cnt - we0, 32'd1);
    chk("sw_mem_a", last_a, 32'd2);
    chk("sw_mem", mem[2], 32'hDEADBEEF);
    chk("sw_err", {31'b0, r_err}, 32'd0);
    chk("sw_rdata", r_data, 32'd0);
    chk("sw_pulse", {31'b0, r_after}, 32'd0);

    req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    chk("lw_lat", lat, 32'd2);
    chk("lw_rdata", r_data, 32'hDEADBEEF);
    chk("lw_err", {31'b0, r_err}, 32'd0);
    chk("lw_ready_after", {31'b0, req_ready}, 32'd1);

    mem[3] = 32'h11223344;
    req(1'b1, 2'b00, 1'b0, 32'h0D, 32'h000000AB);
    chk("sb_lat", lat, 32'd3);
    chk("sb_we_count", we_cnt - we0, 32'd1);
    chk("sb_mem_a", last_a, 32'd3);
    chk("sb_mem", mem[3], 32'h1122AB44);
    req(1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234CAFE);
    chk("sh_lat", lat, 32'd3);
    chk("sh_mem", mem[3], 32'hCAFEAB44);

    mem[0] = 32'h80FF7F01;
    req(1'b0, 2'b00, 1'b0, 32'h01, 32'h0);
    chk("lb_01", r_data, 32'h0000007F);
    req(1'b0, 2'b00, 1'b0, 32'h02, 32'h0);
    chk("lb_02", r_data, 32'hFFFFFFFF);
    req(1'b0, 2'b00, 1'b1, 32'h02, 32'h0);
    chk("lbu_02", r_data, 32'h000000FF);
    req(1'b0, 2'b00, 1'b0, 32'h03, 32'h0);
    chk("lb_03", r_data, 32'hFFFFFF80);
    req(1'b0, 2'b01, 1'b0, 32'h02, 32'h0);
    chk("lh_02", r_data, 32'hFFFF80FF);
    req(1'b0, 2'b01, 1'b1, 32'h02, 32'h0);
    chk("lhu_02", r_data, 32'h000080FF);
    req(1'b0, 2'b01, 1'b0, 32'h00, 32'h0);
    chk("lh_00", r_data, 32'h00007F01);
    chk("lh_00_lat", lat, 32'd2);

    req(1'b0, 2'b01, 1'b0, 32'h03, 32'h0);
    chk("lh3_err", {31'b0, r_err}, 32'd1);
    chk("lh3_rdata", r_data, 32'd0);
    chk("lh3_lat", lat, 32'd1);
    req(1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF);
    chk("sw6_err", {31'b0, r_err}, 32'd1);
    chk("sw6_lat", lat, 32'd1);
    chk("sw6_no_we", we_cnt - we0, 32'd0);
    chk("sw6_mem", mem[1], 32'd0);
    req(1'b1, 2'b11, 1'b0, 32'h04, 32'hFFFFFFFF);
    chk("sz11_err", {31'b0, r_err}, 32'd1);
    chk("sz11_rdata", r_data, 32'd0);
    chk("sz11_no_we", we_cnt - we0, 32'd0);
    chk("sz11_err_after", {31'b0, resp_err}, 32'd0);

    mem[5] = 32'h55667788;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h99;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    we0 = we_cnt;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
    chk("rstmid_mem_a", mem_a, 32'd0);
    seen_vld = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 seen_vld = seen_vld | resp_valid;
    end
    chk("rstmid_no_resp", {31'b0, seen_vld}, 32'd0);
    chk("rstmid_no_we", we_cnt - we0, 32'd0);
    chk("rstmid_mem", mem[5], 32'h55667788);

    mem[0] = 32'h0;
    req(1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678);
`ifdef LSU_RANGE_CHECK_EN
    chk("range_err", {31'b0, r_err}, 32'd1);
    chk("range_mem0", mem[0], 32'h0);
`else
    chk("range_err", {31'b0, r_err}, 32'd0);
    chk("range_mem0", mem[0], 32'h12345678);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
